seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_if.sv | 25 ++
 rtl/seq_alu.sv | 216 +++++++++++++++++++++
 tb/tb_seq_alu.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: valid/ready request carrying op and operands,
// valid/ready response carrying result and the illegal-op qualifier.
interface seq_alu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            illegal;

    modport master (
        output in_valid, op, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, illegal
    );

    modport slave (
        input  in_valid, op, src_a, src_b, out_ready,
        output in_ready, out_valid, result, illegal
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU, one op in flight: base ops 1 cycle; with SEQ_ALU_MULDIV_EN, MUL XLEN+1, DIV XLEN+2.
// Result holds in DONE until out_ready; in_ready is high only in IDLE, so a new request waits one cycle after handshake.
module seq_alu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic     clk,
    input  logic     reset,
    seq_alu_if.slave bus
);
    localparam int SH_W = $clog2(XLEN);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SLL  = 5'd2;
    localparam logic [4:0] OP_SLT  = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;

    if (XLEN < 8 || XLEN > 64 || (XLEN % 2) != 0) begin : g_bad_xlen
        $error("seq_alu: XLEN must be even and within 8..64");
    end
    if (CNT_W < $clog2(XLEN + 1)) begin : g_bad_cnt_w
        $error("seq_alu: CNT_W too narrow to hold XLEN");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DONE = 2'd1
`ifdef SEQ_ALU_MULDIV_EN
        , ST_MUL = 2'd2,
        ST_DIV  = 2'd3
`endif
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] base_res;
    logic            base_ok;

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);

    always_comb begin
        base_res = '0;
        base_ok  = 1'b1;
        shamt    = bus.src_b[SH_W-1:0];
        case (bus.op)
            OP_ADD:  base_res = bus.src_a + bus.src_b;
            OP_SUB:  base_res = bus.src_a - bus.src_b;
            OP_SLL:  base_res = bus.src_a << shamt;
            OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
            OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (bus.src_a < bus.src_b)};
            OP_XOR:  base_res = bus.src_a ^ bus.src_b;
            OP_SRL:  base_res = bus.src_a >> shamt;
            OP_SRA:  base_res = $signed(bus.src_a) >>> shamt;
            OP_OR:   base_res = bus.src_a | bus.src_b;
            OP_AND:  base_res = bus.src_a & bus.src_b;
            default: base_ok  = 1'b0;
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    localparam logic [4:0]      OP_MUL    = 5'd16;
    localparam logic [4:0]      OP_MULH   = 5'd17;
    localparam logic [4:0]      OP_MULHSU = 5'd18;
    localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    logic [CNT_W-1:0]  cnt;
    logic              is_mul, is_div, div_signed, div_zero, div_ovf;
    logic              a_neg, b_neg, mul_a_signed;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] acc, mcand, addend, acc_nx;
    logic [XLEN-1:0]   mplier, quo, rem, dvsr;
    logic              mul_b_signed, mul_hi, neg_q, neg_r, want_rem;
    logic [XLEN:0]     rem_sh, diff;

    assign is_mul       = (bus.op[4:2] == 3'b100);
    assign is_div       = (bus.op[4:2] == 3'b101);
    assign div_signed   = ~bus.op[0];
    assign a_neg        = bus.src_a[XLEN-1];
    assign b_neg        = bus.src_b[XLEN-1];
    assign mul_a_signed = (bus.op == OP_MULH) || (bus.op == OP_MULHSU);
    assign div_zero     = (bus.src_b == '0);
    assign div_ovf      = div_signed && (bus.src_a == MOST_NEG) && (bus.src_b == '1);
    assign a_mag        = (div_signed && a_neg) ? -bus.src_a : bus.src_a;
    assign b_mag        = (div_signed && b_neg) ? -bus.src_b : bus.src_b;

    // A signed multiplier's top bit carries weight -2^(XLEN-1), so the last step subtracts.
    assign addend = (mul_b_signed && cnt == CNT_W'(1)) ? -mcand : mcand;
    assign acc_nx = mplier[0] ? acc + addend : acc;
    assign rem_sh = {rem, quo[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dvsr};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_nx = ST_DONE;
`ifdef SEQ_ALU_MULDIV_EN
                    if (is_mul)                               state_nx = ST_MUL;
                    else if (is_div && !div_zero && !div_ovf) state_nx = ST_DIV;
`endif
                end
            end
`ifdef SEQ_ALU_MULDIV_EN
            ST_MUL: if (cnt == CNT_W'(1)) state_nx = ST_DONE;
            ST_DIV: if (cnt == '0)        state_nx = ST_DONE;
`endif
            ST_DONE: if (bus.out_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.result  <= '0;
            bus.illegal <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        bus.result  <= base_res;
                        bus.illegal <= ~base_ok;
`ifdef SEQ_ALU_MULDIV_EN
                        if (is_mul || is_div) bus.illegal <= 1'b0;
                        // Degenerate divides resolve at acceptance; op[1] selects remainder.
                        if (is_div && div_zero)
                            bus.result <= bus.op[1] ? bus.src_a : '1;
                        else if (is_div && div_ovf)
                            bus.result <= bus.op[1] ? '0 : MOST_NEG;
`endif
                    end
                end
`ifdef SEQ_ALU_MULDIV_EN
                ST_MUL: begin
                    if (cnt == CNT_W'(1))
                        bus.result <= mul_hi ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
                end
                ST_DIV: begin
                    if (cnt == '0)
                        bus.result <= want_rem ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef SEQ_ALU_MULDIV_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            mul_b_signed <= 1'b0;
            mul_hi       <= 1'b0;
            quo          <= '0;
            rem          <= '0;
            dvsr         <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            want_rem     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid && is_mul) begin
                        cnt          <= CNT_W'(XLEN);
                        acc          <= '0;
                        mcand        <= {{XLEN{mul_a_signed & a_neg}}, bus.src_a};
                        mplier       <= bus.src_b;
                        mul_b_signed <= (bus.op == OP_MULH);
                        mul_hi       <= (bus.op != OP_MUL);
                    end else if (bus.in_valid && is_div && !div_zero && !div_ovf) begin
                        cnt      <= CNT_W'(XLEN);
                        rem      <= '0;
                        quo      <= a_mag;
                        dvsr     <= b_mag;
                        neg_q    <= div_signed & (a_neg ^ b_neg);
                        neg_r    <= div_signed & a_neg;
                        want_rem <= bus.op[1];
                    end
                end
                ST_MUL: begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                end
                ST_DIV: begin
                    // quo doubles as the dividend shifter; quotient bits enter at the bottom.
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                        quo <= {quo[XLEN-2:0], ~diff[XLEN]};
                        rem <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed bench for seq_alu: an arithmetic reference model drives a per-cycle checker,
// directed vectors pin literal results and latencies. Works with or without SEQ_ALU_MULDIV_EN.
module tb_seq_alu;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    seq_alu_if #(.XLEN(XLEN)) bus ();

    seq_alu #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
`ifdef SEQ_ALU_MULDIV_EN
        longint          p;
        longint unsigned up;
`endif
        r   = '0;
        ill = 1'b0;
        lat = 1;
        case (op)
            5'd0: r = a + b;
            5'd1: r = a - b;
            5'd2: r = a << b[4:0];
            5'd3: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            5'd4: r = (a < b) ? 32'd1 : 32'd0;
            5'd5: r = a ^ b;
            5'd6: r = a >> b[4:0];
            5'd7: r = 32'(int'(a) >>> b[4:0]);
            5'd8: r = a | b;
            5'd9: r = a & b;
`ifdef SEQ_ALU_MULDIV_EN
            5'd16: begin up = {32'h0, a} * {32'h0, b}; r = up[31:0];  lat = 33; end
            5'd17: begin p = longint'(int'(a)) * longint'(int'(b)); r = p[63:32]; lat = 33; end
            5'd18: begin p = longint'(int'(a)) * longint'({32'h0, b}); r = p[63:32]; lat = 33; end
            5'd19: begin up = {32'h0, a} * {32'h0, b}; r = up[63:32]; lat = 33; end
            5'd20, 5'd21, 5'd22, 5'd23: begin
                if (b == 32'h0) begin
                    r = (op >= 5'd22) ? a : 32'hFFFF_FFFF;
                end else if ((op == 5'd20 || op == 5'd22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r = (op == 5'd22) ? 32'h0 : 32'h8000_0000;
                end else begin
                    lat = 34;
                    case (op)
                        5'd20:   r = 32'(int'(a) / int'(b));
                        5'd21:   r = a / b;
                        5'd22:   r = 32'(int'(a) % int'(b));
                        default: r = a % b;
                    endcase
                end
            end
`endif
            default: ill = 1'b1;
        endcase
    endfunction

    // Per-cycle checker: samples at negedge, inputs change just after posedge.
    initial begin
        bit          busy;
        int          remain;
        logic [31:0] m_res;
        logic        m_ill;
        int          m_lat;
        busy   = 1'b0;
        remain = 0;
        m_res  = '0;
        m_ill  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_out_valid", bus.out_valid, 0);
                chk("rst_result", bus.result, 0);
                chk("rst_illegal", bus.illegal, 0);
                chk("rst_in_ready", bus.in_ready, 1);
                busy = 1'b0;
            end else if (!busy) begin
                chk("idle_in_ready", bus.in_ready, 1);
                chk("idle_out_valid", bus.out_valid, 0);
                if (bus.in_valid) begin
                    model(bus.op, bus.src_a, bus.src_b, m_res, m_ill, m_lat);
                    busy   = 1'b1;
                    remain = m_lat;
                end
            end else begin
                if (remain > 0) remain--;
                chk("busy_in_ready", bus.in_ready, 0);
                if (remain > 0) begin
                    chk("early_out_valid", bus.out_valid, 0);
                end else begin
                    chk("out_valid", bus.out_valid, 1);
                    chk("result", bus.result, m_res);
                    chk("illegal", bus.illegal, m_ill);
                    if (bus.out_ready) busy = 1'b0;
                end
            end
        end
    end

    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int hold,
                          output logic [31:0] res, output logic ill, output int lat);
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.src_a     = a;
        bus.src_b     = b;
        bus.out_ready = (hold == 0);
        @(posedge clk); #1;
        // Scramble the inputs: a captured operation must not notice.
        bus.in_valid = 1'b0;
        bus.op       = 5'($urandom);
        bus.src_a    = $urandom;
        bus.src_b    = $urandom;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_within_budget", bus.out_valid, 1);
        res = bus.result;
        ill = bus.illegal;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        if (hold > 0) begin
            chk("held_result", bus.result, res);
            chk("held_illegal", bus.illegal, ill);
            chk("held_out_valid", bus.out_valid, 1);
            chk("held_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_handshake", bus.in_ready, 1);
    endtask

    task automatic dir(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_ill, input int exp_lat, input int hold);
        logic [31:0] res;
        logic        ill;
        int          lat;
        run_op(op, a, b, hold, res, ill, lat);
        chk({name, "_result"}, res, exp_res);
        chk({name, "_illegal"}, ill, exp_ill);
        chk({name, "_latency"}, lat, exp_lat);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [5];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        logic [31:0] res;
        logic        ill;
        int          lat;
        int          k;
        logic [4:0]  op;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_result", bus.result, 0);
        chk("reset_in_ready", bus.in_ready, 1);
        reset = 1'b0;

        dir("add_wrap", 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1, 0);
        dir("slt_neg", 5'd3, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1, 0);
        dir("sltu", 5'd4, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1, 0);
        dir("sra", 5'd7, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0, 1, 0);
        dir("srl", 5'd6, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, 1, 0);
        dir("undef_op", 5'd31, 32'h5, 32'h6, 32'h0, 1'b1, 1, 0);
        dir("backpressure", 5'd1, 32'h10, 32'h3, 32'hD, 1'b0, 1, 5);
`ifdef SEQ_ALU_MULDIV_EN
        dir("mulh", 5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 33, 0);
        dir("mulhu", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, 0);
        dir("mul_neg", 5'd16, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33, 0);
        dir("div_neg", 5'd20, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 1'b0, 34, 0);
        dir("rem_neg", 5'd22, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 1'b0, 34, 0);
        dir("divu", 5'd21, 32'd100, 32'd7, 32'd14, 1'b0, 34, 0);
        dir("div_by_zero", 5'd20, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, 0);
        dir("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1, 0);
        dir("mul_3x4", 5'd16, 32'd3, 32'd4, 32'd12, 1'b0, 33, 0);
        dir("div_bp", 5'd23, 32'd100, 32'd7, 32'd2, 1'b0, 34, 5);
`else
        dir("mul_3x4", 5'd16, 32'd3, 32'd4, 32'h0, 1'b1, 1, 0);
        dir("div_absent", 5'd20, 32'd5, 32'd0, 32'h0, 1'b1, 1, 0);
`endif

        // Reset in the middle of an operation (a DIV when the datapath exists).
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.op        = 5'd20;
        bus.src_a     = 32'hFFFF_FF9C;
        bus.src_b     = 32'd7;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        chk("mid_reset_out_valid", bus.out_valid, 0);
        chk("mid_reset_in_ready", bus.in_ready, 1);
        chk("mid_reset_result", bus.result, 0);
        @(posedge clk); #1;
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        dir("add_after_reset", 5'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1, 0);

        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 19);
            if (k < 10)      op = 5'(k);
            else if (k < 18) op = 5'(k + 6);
            else             op = 5'($urandom);
            run_op(op, pick_operand(), pick_operand(), $urandom_range(0, 2), res, ill, lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
